uart_fifo_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_fifo_transmitter.sv | 137 +++++++++++++
 tb/tb_uart_fifo_transmitter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state codes and frame timing.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    // Clock cycles one complete frame occupies on the line.
    function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                        input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO holding characters waiting for the transmitter.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is left unreset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_fifo_transmitter.sv
// UART transmitter fed by an internal FIFO; queued characters leave back-to-back with no idle gap.
module uart_fifo_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        write_data,
    input  logic                        write_req,
    output logic                        ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t            state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic                 stop_idx_reg, stop_idx_next;
    logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic                 tx_reg, tx_next;
    logic                 bit_end;
    logic                 stop_last;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (write_req),
        .push_data (write_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bit_end   = (baud_cnt_reg == BIT_LAST);
    assign stop_last = (stop_idx_reg == STOP_LAST);
    // A frame starts from IDLE, or directly out of the final stop bit so the line never idles.
    assign fifo_pop  = !fifo_empty &&
                       ((state_reg == ST_IDLE) || (state_reg == ST_STOP && bit_end && stop_last));

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_last) state_next = ST_IDLE;
                    else           stop_idx_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (fifo_pop) begin
            shift_next    = fifo_head;
            bit_idx_next  = '0;
            stop_idx_next = 1'b0;
            baud_cnt_next = '0;
            state_next    = ST_START;
        end
    end

    // Parity is reduced over the latched character, which is indexed rather than shifted.
    always_comb begin
        tx_next = 1'b1;
        case (state_reg)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_reg[bit_idx_reg];
            ST_PARITY: tx_next = (PARITY == PARITY_EVEN) ? ^shift_reg : ~^shift_reg;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            baud_cnt_reg <= baud_cnt_next;
            tx_reg       <= tx_next;
        end
    end

    assign tx    = tx_reg;
    assign ready = !fifo_full;
    assign busy  = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Randomised scoreboard bench for uart_fifo_transmitter across four frame formats in parallel.
`timescale 1ns/1ps
module tb_uart_fifo_transmitter;

    localparam int N_INST = 4;

    typedef struct {
        int accept;
        int pop;
        int fin;
    } ent_t;

    typedef struct {
        int data;
        int start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run  = 0;
    int fail_count = 0;

    task automatic check(input int inst, input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            fail_count++;
            if (fail_count <= 40)
                $display("FAIL u%0d %s: got %0d expected %0d (cycle %0d)", inst, name, got, want, cyc);
        end
    endtask

    generate
        for (genvar gi = 0; gi < N_INST; gi++) begin : g_u
            localparam int C     = 4;
            localparam int DB    = (gi == 3) ? 7 : 8;
            localparam int PAR   = (gi == 1) ? 2 : ((gi == 2) ? 1 : 0);
            localparam int SB    = (gi == 3) ? 2 : 1;
            localparam int DEPTH = (gi == 1) ? 2 : ((gi == 3) ? 8 : 4);
            localparam int NSLOT = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
            localparam int FL    = NSLOT * C;
            localparam int FIRST = (gi == 0) ? 'hA5 : ((gi == 3) ? 'h41 : 'h07);

            logic                   rst        = 1'b1;
            logic [DB-1:0]          write_data = '0;
            logic                   write_req  = 1'b0;
            logic                   ready;
            logic                   busy;
            logic                   tx;
            logic [$clog2(DEPTH):0] fifo_count;
            bit                     done       = 1'b0;

            ent_t ent_q[$];
            exp_t exp_q[$];
            int   last_fin = -1000;
            logic s_arr [FL];

            uart_fifo_transmitter #(
                .CLKS_PER_BIT (C),
                .DATA_BITS    (DB),
                .PARITY       (PAR),
                .STOP_BITS    (SB),
                .FIFO_DEPTH   (DEPTH)
            ) u_dut (
                .clk        (clk),
                .reset      (rst),
                .write_data (write_data),
                .write_req  (write_req),
                .ready      (ready),
                .fifo_count (fifo_count),
                .busy       (busy),
                .tx         (tx)
            );

            // Characters sitting in the FIFO after edge e: accepted, not yet taken for transmission.
            function automatic int model_count(input int e);
                int n = 0;
                foreach (ent_q[k])
                    if (ent_q[k].accept <= e && e < ent_q[k].pop) n++;
                return n;
            endfunction

            function automatic int model_busy(input int e);
                foreach (ent_q[k])
                    if (ent_q[k].accept <= e && e < ent_q[k].fin) return 1;
                return 0;
            endfunction

            // A character is taken one edge after acceptance or when the previous frame ends,
            // whichever is later; its start bit appears on the following edge.
            task automatic accept_entry(input int a, input int d);
                int p;
                int s;
                p = (last_fin > a + 1) ? last_fin : a + 1;
                s = p + 1;
                last_fin = s + FL - 1;
                ent_q.push_back('{accept: a, pop: p, fin: last_fin});
                exp_q.push_back('{data: d % (1 << DB), start: s});
            endtask

            task automatic step(input bit req, input int d);
                int e;
                int n;
                @(negedge clk);
                e = cyc;
                while (ent_q.size() > 0 && ent_q[0].fin < e) void'(ent_q.pop_front());
                n = model_count(e);
                check(gi, "fifo_count", int'(fifo_count), n);
                check(gi, "busy", int'(busy), model_busy(e));
                check(gi, "ready", int'(ready), (n < DEPTH) ? 1 : 0);
                write_req  = req;
                write_data = DB'(d);
                if (req && n < DEPTH) accept_entry(e + 1, d);
            endtask

            task automatic drain();
                int guard = 0;
                while (cyc <= last_fin + 1 && guard < 4000) begin
                    step(1'b0, 0);
                    guard++;
                end
                step(1'b0, 0);
                check(gi, "scoreboard_empty", exp_q.size(), 0);
            endtask

            task automatic score_frame(input int t0);
                logic [15:0] obs;
                logic [15:0] want;
                bit          glitch;
                int          ones;
                exp_t        x;
                obs    = '0;
                want   = '0;
                glitch = 1'b0;
                for (int s = 0; s < NSLOT; s++) begin
                    obs[s] = s_arr[s * C + C / 2];
                    for (int k = 0; k < C; k++)
                        if (s_arr[s * C + k] !== obs[s]) glitch = 1'b1;
                end
                check(gi, "frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() == 0) return;
                x = exp_q.pop_front();
                for (int i = 0; i < DB; i++) want[1 + i] = x.data[i];
                ones = $countones(x.data);
                if (PAR != 0) want[1 + DB] = (PAR == 2) ? ones[0] : ~ones[0];
                for (int j = 0; j < SB; j++) want[NSLOT - SB + j] = 1'b1;
                check(gi, "frame_start_cycle", t0, x.start);
                check(gi, "frame_bits", int'({glitch, obs}), int'(want));
                $display("[u%0d] frame data=0x%0h start=%0d bits=0x%0h", gi, x.data, t0, obs);
            endtask

            initial begin : monitor
                int t0;
                bit aborted;
                forever begin
                    @(negedge clk);
                    if (!rst && tx === 1'b0) begin
                        t0 = cyc;
                        aborted = 1'b0;
                        s_arr[0] = tx;
                        for (int k = 1; k < FL; k++) begin
                            @(negedge clk);
                            if (rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            s_arr[k] = tx;
                        end
                        if (!aborted) score_frame(t0);
                    end
                end
            end

            initial begin : stimulus
                repeat (3) @(negedge clk);
                check(gi, "reset_tx", int'(tx), 1);
                check(gi, "reset_count", int'(fifo_count), 0);
                check(gi, "reset_busy", int'(busy), 0);
                check(gi, "reset_ready", int'(ready), 1);
                rst = 1'b0;

                // single character of the format under test
                step(1'b1, FIRST);
                drain();

                // six back-to-back requests: later ones bounce off a full FIFO
                for (int i = 0; i < 6; i++) step(1'b1, 'h10 + i);
                drain();

                // two queued characters must leave with zero idle cycles between them
                step(1'b1, 'h55);
                step(1'b1, 'hAA);
                drain();

                // reset in the middle of the first frame's data bits, then recover
                step(1'b1, 'h00);
                step(1'b1, 'h22);
                step(1'b1, 'h23);
                repeat (3 * C) step(1'b0, 0);
                @(negedge clk);
                rst       = 1'b1;
                write_req = 1'b0;
                #1;
                check(gi, "midframe_reset_tx", int'(tx), 1);
                check(gi, "midframe_reset_count", int'(fifo_count), 0);
                check(gi, "midframe_reset_busy", int'(busy), 0);
                ent_q.delete();
                exp_q.delete();
                last_fin = -1000;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                step(1'b1, 'h3C);
                drain();

                for (int i = 0; i < 250; i++)
                    step(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                         int'($urandom_range(0, (1 << DB) - 1)));
                drain();
                done = 1'b1;
            end
        end
    endgenerate

    initial begin : finisher
        int waited = 0;
        while (!(g_u[0].done && g_u[1].done && g_u[2].done && g_u[3].done) && waited < 60000) begin
            @(negedge clk);
            waited++;
        end
        check(-1, "all_instances_finished", (waited < 60000) ? 1 : 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
